// File: rtl/sap_1_instruction_decoder.sv
// SAP-1 opcode decoder: registers a one-hot strobe for LDA/ADD/SUB/OUT/HLT,
// with ILL flagging every other opcode. All six outputs are low only in reset.
module sap_1_instruction_decoder (
    input  logic       Clk,
    input  logic       Clr_n,
    input  logic [7:4] i,
    output logic       LDA,
    output logic       ADD,
    output logic       SUB,
    output logic       OUT,
    output logic       HLT,
    output logic       ILL
);

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    // Bit order matches the output concatenation {LDA, ADD, SUB, OUT, HLT, ILL}.
    logic [5:0] strobe_d;
    logic [5:0] strobe_q;

    always_comb begin
        strobe_d = '0;
        case (i)
            OP_LDA:  strobe_d = 6'b100000;
            OP_ADD:  strobe_d = 6'b010000;
            OP_SUB:  strobe_d = 6'b001000;
            OP_OUT:  strobe_d = 6'b000100;
            OP_HLT:  strobe_d = 6'b000010;
            default: strobe_d = 6'b000001;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clr_n) begin
            strobe_q <= '0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    assign {LDA, ADD, SUB, OUT, HLT, ILL} = strobe_q;

endmodule

// File: tb/tb_sap_1_instruction_decoder.sv
// Scoreboard bench for sap_1_instruction_decoder: stimulus queues the expected
// strobe vector for each edge, a monitor compares one cycle later.
module tb_sap_1_instruction_decoder;

    logic       Clk = 1'b0;
    logic       Clr_n;
    logic [7:4] i;
    logic       LDA, ADD, SUB, OUT, HLT, ILL;

    always #5 Clk = ~Clk;

    sap_1_instruction_decoder dut (
        .Clk   (Clk),
        .Clr_n (Clr_n),
        .i     (i),
        .LDA   (LDA),
        .ADD   (ADD),
        .SUB   (SUB),
        .OUT   (OUT),
        .HLT   (HLT),
        .ILL   (ILL)
    );

    // Expected vectors in {LDA, ADD, SUB, OUT, HLT, ILL} order.
    localparam logic [5:0] E_RST = 6'b000000;
    localparam logic [5:0] E_LDA = 6'b100000;
    localparam logic [5:0] E_ADD = 6'b010000;
    localparam logic [5:0] E_SUB = 6'b001000;
    localparam logic [5:0] E_OUT = 6'b000100;
    localparam logic [5:0] E_HLT = 6'b000010;
    localparam logic [5:0] E_ILL = 6'b000001;

    logic [5:0] exp_q[$];
    string      name_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Drive on the falling edge; optional mid-cycle glitches on i or Clr_n
    // are restored well before the next rising edge.
    task automatic apply(input logic clr, input logic [3:0] op, input logic [5:0] exp,
                         input string name, input logic glitch_en,
                         input logic [3:0] glitch_op, input logic clr_pulse);
        @(negedge Clk);
        Clr_n = clr;
        i     = op;
        exp_q.push_back(exp);
        name_q.push_back(name);
        if (glitch_en) begin
            #1 i = glitch_op;
            #1 i = op;
        end
        if (clr_pulse) begin
            #1 Clr_n = 1'b0;
            #1 Clr_n = clr;
        end
    endtask

    task automatic vec(input logic clr, input logic [3:0] op, input logic [5:0] exp,
                       input string name);
        apply(clr, op, exp, name, 1'b0, 4'b0000, 1'b0);
    endtask

    // Monitor: every rising edge produces one output vector.
    initial begin
        logic [5:0] got;
        logic [5:0] e;
        string      nm;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {LDA, ADD, SUB, OUT, HLT, ILL};
                n_vec++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL %s: got {LDA,ADD,SUB,OUT,HLT,ILL}=%b, expected %b", nm, got, e);
                end
            end
        end
    end

    initial begin
        Clr_n = 1'b0;
        i     = 4'b1111;

        // Reset held with HLT opcode present, then release.
        vec(1'b0, 4'b1111, E_RST, "reset_0");
        vec(1'b0, 4'b1111, E_RST, "reset_1");
        vec(1'b1, 4'b1111, E_HLT, "release_hlt");

        // Each supported opcode back to back.
        vec(1'b1, 4'b0000, E_LDA, "b2b_lda");
        vec(1'b1, 4'b0001, E_ADD, "b2b_add");
        vec(1'b1, 4'b0010, E_SUB, "b2b_sub");
        vec(1'b1, 4'b1110, E_OUT, "b2b_out");
        vec(1'b1, 4'b1111, E_HLT, "b2b_hlt");

        // Illegal sweep 0011..1101.
        for (int k = 3; k <= 13; k++) begin
            vec(1'b1, 4'(k), E_ILL, $sformatf("ill_%b", 4'(k)));
        end

        // Mid-cycle glitch on i is ignored.
        apply(1'b1, 4'b0001, E_ADD, "glitch_add_0", 1'b1, 4'b0010, 1'b0);
        apply(1'b1, 4'b0001, E_ADD, "glitch_add_1", 1'b1, 4'b0010, 1'b0);
        vec(1'b1, 4'b0001, E_ADD, "glitch_add_2");

        // Reset while OUT is asserted, then an async-only pulse that must not clear.
        vec(1'b1, 4'b1110, E_OUT, "out_pre");
        vec(1'b0, 4'b1110, E_RST, "out_reset");
        vec(1'b1, 4'b1110, E_OUT, "out_release");
        apply(1'b1, 4'b1110, E_OUT, "out_async_pulse", 1'b0, 4'b0000, 1'b1);
        vec(1'b1, 4'b1110, E_OUT, "out_after_pulse");

        // Reset mid-HLT and with an illegal opcode present; HLT is not sticky.
        vec(1'b1, 4'b1111, E_HLT, "hlt_pre");
        vec(1'b0, 4'b1111, E_RST, "hlt_reset");
        vec(1'b0, 4'b0101, E_RST, "ill_in_reset");
        vec(1'b1, 4'b0000, E_LDA, "hlt_release_lda");
        vec(1'b1, 4'b1111, E_HLT, "hlt_then");
        vec(1'b1, 4'b0011, E_ILL, "hlt_not_sticky");

        // Classic program sequence, each opcode held three cycles.
        for (int r = 0; r < 3; r++) vec(1'b1, 4'b0000, E_LDA, "seq_lda");
        for (int r = 0; r < 3; r++) vec(1'b1, 4'b0001, E_ADD, "seq_add");
        for (int r = 0; r < 3; r++) vec(1'b1, 4'b0010, E_SUB, "seq_sub");
        for (int r = 0; r < 3; r++) vec(1'b1, 4'b1110, E_OUT, "seq_out");
        for (int r = 0; r < 3; r++) vec(1'b1, 4'b1111, E_HLT, "seq_hlt");

        // Bounded drain of the scoreboard.
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(posedge Clk);
        #3;
        if (exp_q.size() > 0) begin
            n_err += exp_q.size();
            $display("FAIL drain: %0d expected vectors never observed, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
